// File: rtl/mult_pkg.sv
// Shared types and default parameters for the multiplier issue stage.
package mult_pkg;

  localparam int unsigned M_DEF       = 8;
  localparam int unsigned N_DEF       = 8;
  localparam int unsigned DEPTH_DEF   = 4;
  localparam int unsigned TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/operand_fifo.sv
// Synchronous operand FIFO with wrap-around pointers and an occupancy count.
module operand_fifo #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [W-1:0]            wdata_i,
  output logic [W-1:0]            rdata_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_i && (count_q < CW'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  // Pointer and occupancy bookkeeping; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/mult_issue_ctrl.sv
// Operand issue / result capture around a shift-add multiplier, with zero bypass and watchdog.
module mult_issue_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned M       = M_DEF,
  parameter int unsigned N       = N_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [M-1:0]   in_d,
  input  logic [N-1:0]   in_q,
  output logic           mul_start,
  output logic [M-1:0]   mul_d,
  output logic [N-1:0]   mul_q,
  input  logic           mul_done,
  input  logic [M+N-1:0] mul_prod,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [M+N-1:0] out_prod,
  output logic           busy,
  output logic           timeout_err
);

  localparam int unsigned PW  = M + N;
  localparam int unsigned FCW = $clog2(DEPTH) + 1;
  localparam int unsigned WCW = $clog2(TIMEOUT);

  state_e         state_q, state_d;
  logic [M-1:0]   mul_d_q, mul_d_d;
  logic [N-1:0]   mul_q_q, mul_q_d;
  logic [PW-1:0]  out_prod_q, out_prod_d;
  logic [WCW-1:0] wd_cnt_q, wd_cnt_d;
  logic           mul_start_q, mul_start_d;
  logic           out_valid_q, out_valid_d;
  logic           timeout_err_q, timeout_err_d;

  logic           fifo_push;
  logic           fifo_pop;
  logic           fifo_empty;
  logic [FCW-1:0] fifo_count;
  logic [PW-1:0]  fifo_head;
  logic [M-1:0]   head_d;
  logic [N-1:0]   head_q;
  logic           launch;

  assign in_ready  = (fifo_count < FCW'(DEPTH));
  assign fifo_push = in_valid && in_ready;
  assign head_d    = fifo_head[PW-1:N];
  assign head_q    = fifo_head[N-1:0];

  operand_fifo #(
    .W     (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i ({in_d, in_q}),
    .rdata_o (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      mul_d_q       <= '0;
      mul_q_q       <= '0;
      out_prod_q    <= '0;
      wd_cnt_q      <= '0;
      mul_start_q   <= 1'b0;
      out_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mul_d_q       <= mul_d_d;
      mul_q_q       <= mul_q_d;
      out_prod_q    <= out_prod_d;
      wd_cnt_q      <= wd_cnt_d;
      mul_start_q   <= mul_start_d;
      out_valid_q   <= out_valid_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state: pop/launch from IDLE or on HOLD hand-off, watchdog in WAIT.
  always_comb begin
    state_d       = state_q;
    mul_d_d       = mul_d_q;
    mul_q_d       = mul_q_q;
    out_prod_d    = out_prod_q;
    wd_cnt_d      = wd_cnt_q;
    timeout_err_d = timeout_err_q;
    fifo_pop      = 1'b0;
    launch        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) launch = 1'b1;
      end
      ST_ISSUE: begin
        wd_cnt_d = '0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (mul_done) begin
          out_prod_d = mul_prod;
          state_d    = ST_HOLD;
        end else if (wd_cnt_q == WCW'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + WCW'(1);
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          if (!fifo_empty) launch = 1'b1;
          else             state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Shared pop path: zero operands skip the multiplier entirely.
    if (launch) begin
      fifo_pop = 1'b1;
      mul_d_d  = head_d;
      mul_q_d  = head_q;
      if ((head_d == '0) || (head_q == '0)) begin
        out_prod_d = '0;
        state_d    = ST_HOLD;
      end else begin
        state_d = ST_ISSUE;
      end
    end

    mul_start_d = (state_d == ST_ISSUE);
    out_valid_d = (state_d == ST_HOLD);
  end

  assign mul_start   = mul_start_q;
  assign mul_d       = mul_d_q;
  assign mul_q       = mul_q_q;
  assign out_valid   = out_valid_q;
  assign out_prod    = out_prod_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Directed self-checking bench for mult_issue_ctrl with a behavioural multiplier.
module tb_mult_issue_ctrl;

  localparam int unsigned M       = 8;
  localparam int unsigned N       = 8;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 64;
  localparam int          LAT     = 10;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [M-1:0]   in_d;
  logic [N-1:0]   in_q;
  logic           mul_start;
  logic [M-1:0]   mul_d;
  logic [N-1:0]   mul_q;
  logic           mul_done = 1'b0;
  logic [M+N-1:0] mul_prod = '0;
  logic           out_valid;
  logic           out_ready;
  logic [M+N-1:0] out_prod;
  logic           busy;
  logic           timeout_err;

  int n_cmp = 0;
  int n_err = 0;
  int n_start = 0;

  mult_issue_ctrl #(
    .M (M), .N (N), .DEPTH (DEPTH), .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_d        (in_d),
    .in_q        (in_q),
    .mul_start   (mul_start),
    .mul_d       (mul_d),
    .mul_q       (mul_q),
    .mul_done    (mul_done),
    .mul_prod    (mul_prod),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_prod    (out_prod),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural multiplier: done LAT edges after start unless the job was launched hung.
  logic [15:0] opd = '0;
  logic [15:0] opq = '0;
  int          mcnt = 0;
  bit          mactive = 1'b0;
  bit          mhang = 1'b0;
  bit          hang = 1'b0;

  always @(posedge clk) begin
    mul_done <= 1'b0;
    if (mul_start) begin
      n_start <= n_start + 1;
      mactive <= 1'b1;
      mhang   <= hang;
      mcnt    <= 0;
      opd     <= 16'(mul_d);
      opq     <= 16'(mul_q);
    end else if (mactive && !mhang) begin
      if (mcnt == LAT - 1) begin
        mul_done <= 1'b1;
        mul_prod <= opd * opq;
        mactive  <= 1'b0;
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for out_valid.
  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 300) begin
      tick();
      n++;
    end
    chk(tag, 32'(out_valid), 32'd1);
  endtask

  logic [7:0]  fd [5];
  logic [7:0]  fq [5];
  logic [15:0] fexp [4];
  int          n;
  bit          saw_valid;
  int          s0;

  initial begin
    fd[0] = 8'd255; fq[0] = 8'd255;
    fd[1] = 8'd1;   fq[1] = 8'd1;
    fd[2] = 8'd2;   fq[2] = 8'd128;
    fd[3] = 8'd7;   fq[3] = 8'd9;
    fd[4] = 8'd9;   fq[4] = 8'd9;
    fexp[0] = 16'd65025; fexp[1] = 16'd1; fexp[2] = 16'd256; fexp[3] = 16'd63;

    rst = 1'b0; in_valid = 1'b0; in_d = '0; in_q = '0; out_ready = 1'b0;
    tick();
    // reset values
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mul_start", 32'(mul_start), 32'd0);
    chk("rst_mul_d", 32'(mul_d), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_prod", 32'(out_prod), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // single op 13 x 11
    s0 = n_start;
    in_valid = 1'b1; in_d = 8'd13; in_q = 8'd11;
    tick();
    in_valid = 1'b0;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_nostart_yet", 32'(mul_start), 32'd0);
    tick();
    chk("t1_start", 32'(mul_start), 32'd1);
    chk("t1_mul_d", 32'(mul_d), 32'd13);
    chk("t1_mul_q", 32'(mul_q), 32'd11);
    tick();
    chk("t1_start_pulse", 32'(mul_start), 32'd0);
    wait_out("t1_valid");
    chk("t1_prod", 32'(out_prod), 32'd143);
    repeat (3) tick();
    chk("t1_hold_valid", 32'(out_valid), 32'd1);
    chk("t1_hold_prod", 32'(out_prod), 32'd143);
    chk("t1_nstart", 32'(n_start - s0), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t1_drop_valid", 32'(out_valid), 32'd0);
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // zero bypass 0 x 200; product left unconsumed to block the fill test
    s0 = n_start;
    in_valid = 1'b1; in_d = 8'd0; in_q = 8'd200;
    tick();
    in_valid = 1'b0;
    chk("t2_not_yet", 32'(out_valid), 32'd0);
    tick();
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_prod", 32'(out_prod), 32'd0);
    chk("t2_mul_q", 32'(mul_q), 32'd200);
    tick();
    chk("t2_nstart", 32'(n_start - s0), 32'd0);

    // fill: four accepted, fifth refused
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_d = fd[i]; in_q = fq[i];
      chk($sformatf("t3_in_ready%0d", i), 32'(in_ready), (i < 4) ? 32'd1 : 32'd0);
      tick();
    end
    in_valid = 1'b0;
    chk("t3_full", 32'(in_ready), 32'd0);

    // drain back-to-back with out_ready held high
    out_ready = 1'b1;
    tick();
    chk("t4_start_after_accept", 32'(mul_start), 32'd1);
    chk("t4_in_ready_rise", 32'(in_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      wait_out($sformatf("t4_valid%0d", k));
      chk($sformatf("t4_prod%0d", k), 32'(out_prod), 32'(fexp[k]));
      tick();
      if (k < 3) chk($sformatf("t4_b2b_start%0d", k), 32'(mul_start), 32'd1);
    end
    chk("t4_end_valid", 32'(out_valid), 32'd0);
    chk("t4_end_busy", 32'(busy), 32'd0);
    out_ready = 1'b0;

    // watchdog: first job hangs, second runs normally
    hang = 1'b1;
    in_valid = 1'b1; in_d = 8'd3; in_q = 8'd5;
    tick();
    in_d = 8'd4; in_q = 8'd6;
    tick();
    in_valid = 1'b0;
    chk("t5_start", 32'(mul_start), 32'd1);
    tick();
    hang = 1'b0;
    n = 0;
    saw_valid = 1'b0;
    while (!timeout_err && n < 200) begin
      tick();
      n++;
      if (out_valid) saw_valid = 1'b1;
    end
    chk("t5_err", 32'(timeout_err), 32'd1);
    chk("t5_cycles", 32'(n), 32'(TIMEOUT));
    chk("t5_no_valid", 32'(saw_valid), 32'd0);
    wait_out("t5_next_valid");
    chk("t5_next_prod", 32'(out_prod), 32'd24);
    chk("t5_err_sticky", 32'(timeout_err), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // reset mid-WAIT with three queued
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_d = 8'(10 + i); in_q = 8'd10;
      tick();
    end
    in_valid = 1'b0;
    chk("t6_busy_pre", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_mul_start", 32'(mul_start), 32'd0);
    chk("t6_mul_d", 32'(mul_d), 32'd0);
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_timeout", 32'(timeout_err), 32'd0);
    tick();
    rst = 1'b1;
    saw_valid = 1'b0;
    s0 = n_start;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid || busy || mul_start) saw_valid = 1'b1;
    end
    chk("t6_late_done_ignored", 32'(saw_valid), 32'd0);
    chk("t6_nstart", 32'(n_start - s0), 32'd0);
    chk("t6_out_prod", 32'(out_prod), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_issue_ctrl.md
# mult_issue_ctrl

Operand issue and result-capture stage wrapped around the shift-add multiplier. Accepts operand pairs over a valid/ready handshake, buffers them in a small FIFO, launches one multiplication at a time with a start pulse, and holds each product on a valid/ready output port until consumed. Zero operands bypass the multiplier. A watchdog flags a multiplier that never signals completion.

## Interface
- M, 8, multiplicand (D) width
- N, 8, multiplier (Q) width
- DEPTH, 4, operand FIFO entries; power of two, ≥2
- TIMEOUT, 64, max cycles in WAIT before abort; ≥ N+4
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock, asynchronous, active-low
- in_valid  in  1  operand pair valid
- in_ready  out  1  FIFO not full
- in_d  in  M  multiplicand
- in_q  in  N  multiplier
- mul_start  out  1  one-cycle launch pulse to multiplier
- mul_d  out  M  registered multiplicand, stable from ISSUE through WAIT
- mul_q  out  N  registered multiplier, same hold rule
- mul_done  in  1  multiplier finished; mul_prod valid this cycle
- mul_prod  in  M+N  product from multiplier
- out_valid  out  1  product available
- out_ready  in  1  consumer accepts
- out_prod  out  M+N  product
- busy  out  1  state ≠ IDLE or FIFO non-empty
- timeout_err  out  1  sticky; set on watchdog abort, cleared only by reset

## Operation
- Push when in_valid & in_ready; pop only by FSM. Push and pop in the same cycle both take effect; count unchanged.
- in_ready = (count < DEPTH). Combinational from count only, never from in_valid.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE: if FIFO non-empty, pop head into mul_d/mul_q. If popped d==0 or q==0: load out_prod=0, go HOLD. Else go ISSUE.
- ISSUE: mul_start=1 for exactly this cycle; clear watchdog counter; go WAIT.
- WAIT: if mul_done, capture mul_prod into out_prod, go HOLD. Else increment counter; when counter reaches TIMEOUT-1 with no done, set timeout_err, drop the job (no output), go IDLE.
- HOLD: out_valid=1, out_prod stable. On out_ready: if FIFO non-empty pop head this same cycle and branch as from IDLE (zero bypass → stay HOLD with new 0 product; else → ISSUE); if empty → IDLE.
- mul_done outside WAIT is ignored. mul_done in the same cycle as the watchdog expiring counts as done (no error).
- Product width M+N; no truncation. out_prod holds its last value outside HOLD.
- Reset values: in_ready=1, mul_start=0, mul_d=0, mul_q=0, out_valid=0, out_prod=0, busy=0, timeout_err=0, FIFO empty, state IDLE. Reset mid-operation discards FIFO contents and any in-flight job.

## Timing
- Push into empty idle block at edge 0 → popped at edge 1 → mul_start high in cycle 1–2 → WAIT from edge 2.
- mul_done sampled at edge k → out_valid high from edge k, i.e. visible cycle k..k+1 onward.
- Zero bypass: push edge 0 → out_valid from edge 1.
- Back-to-back: out_ready at edge h with FIFO non-empty → mul_start in cycle after h; no IDLE bubble.
- Full FIFO: in_ready low; rises the cycle after a pop.
- All outputs registered except in_ready and busy (combinational from registers).

## Structure
- Shared package mult_pkg: FSM state enum (2-bit), default widths M/N, TIMEOUT default.
- One sub-module: operand_fifo (synchronous, DEPTH×(M+N), count, wrap-around pointers, same reset).
- Watchdog counter width = clog2(TIMEOUT).

## Test plan
- Single op d=8'd13, q=8'd11 with behavioural multiplier (done after 10 cycles) → mul_start one pulse, out_prod=16'd143, out_valid held until out_ready.
- Zero bypass d=0, q=8'd200 → no mul_start, out_prod=0 one cycle after pop.
- Fill: 5 pushes with out_ready=0 → 4 accepted, in_ready low on 5th; drain yields products in order 255×255=65025, 1×1=1, 2×128=256, 7×9=63.
- Back-to-back with out_ready=1 constant → next mul_start in cycle after each accept, no idle cycle.
- Multiplier never asserts done → timeout_err=1 after TIMEOUT cycles in WAIT, no out_valid, next queued job proceeds normally.
- rst low mid-WAIT with 3 queued → all outputs at reset values, in_ready=1, late mul_done ignored.
